// File: rtl/cpu_clk_controller_if.sv
// Board-side control inputs and CPU-side clock-enable outputs of cpu_clk_controller.
// Signal names are kept from the original flat port list.
interface cpu_clk_if #(
   parameter int BURST_W = 8
);
   logic               run_sw;
   logic               step_btn;
   logic               burst_go;
   logic [BURST_W-1:0] burst_len;
   logic               cpu_halt;
   logic               cpu_ce;
   logic [1:0]         mode;
   logic [15:0]        ce_count;

   modport master (
      output run_sw, step_btn, burst_go, burst_len, cpu_halt,
      input  cpu_ce, mode, ce_count
   );

   modport slave (
      input  run_sw, step_btn, burst_go, burst_len, cpu_halt,
      output cpu_ce, mode, ce_count
   );
endinterface

// File: rtl/cpu_clk_controller.sv
// CPU clock-enable sequencer: free-run, debounced single-step, N-step burst and stop.
// cpu_ce is a one-cycle enable on clkin, never a derived clock.
module cpu_clk_controller #(
   parameter int IN_CLK_FRQ   = 1000000,
   parameter int RUN_FRQ      = 10,
   parameter int DEBOUNCE_CYC = 10000,
   parameter int BURST_W      = 8
) (
   input logic     clkin,
   input logic     reset,
   cpu_clk_if.slave bus
);
   localparam int TICK_PER = IN_CLK_FRQ / RUN_FRQ;
   localparam int TW       = $clog2(TICK_PER);
   localparam int DW       = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_PER - 1);
   localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYC - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_STEP  = 2'd2;
   localparam logic [1:0] S_BURST = 2'd3;

   logic               sync1_q, sync1_d;
   logic               sync2_q, sync2_d;
   logic               db_q, db_d;
   logic [DW-1:0]      db_cnt_q, db_cnt_d;
   logic               step_req_q, step_req_d;
   logic [1:0]         state_q, state_d;
   logic [TW-1:0]      tick_cnt_q, tick_cnt_d;
   logic [BURST_W-1:0] rem_q, rem_d;
   logic               cpu_ce_q, cpu_ce_d;
   logic [15:0]        ce_count_q, ce_count_d;
   logic               timed;
   logic               tick;

   // Button path: level only moves after DEBOUNCE_CYC consecutive disagreeing samples.
   always_comb begin
      sync1_d    = bus.step_btn;
      sync2_d    = sync1_q;
      db_d       = db_q;
      db_cnt_d   = '0;
      if (sync2_q != db_q) begin
         if (db_cnt_q == DB_LAST) begin
            db_d = sync2_q;
         end else begin
            db_cnt_d = db_cnt_q + 1'b1;
         end
      end
      step_req_d = db_d & ~db_q;
   end

   always_comb begin
      timed      = (state_q == S_RUN) || (state_q == S_BURST);
      tick       = timed && (tick_cnt_q == TICK_LAST);
      tick_cnt_d = (timed && !tick) ? tick_cnt_q + 1'b1 : '0;
      state_d    = state_q;
      rem_d      = rem_q;
      cpu_ce_d   = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (!bus.cpu_halt) begin
               if (bus.run_sw) begin
                  state_d = S_RUN;
               end else if (step_req_q) begin
                  state_d = S_STEP;
               end else if (bus.burst_go && (bus.burst_len != '0)) begin
                  state_d = S_BURST;
                  rem_d   = bus.burst_len;
               end
            end
         end
         S_RUN: begin
            if (bus.cpu_halt || !bus.run_sw) begin
               state_d = S_IDLE;
            end else begin
               cpu_ce_d = tick;
            end
         end
         S_STEP: begin
            state_d = S_IDLE;
         end
         default: begin
            // remaining counts down as each pulse is seen, so the final pulse is
            // issued while still in BURST and the exit follows it.
            if (bus.cpu_halt) begin
               state_d = S_IDLE;
               rem_d   = '0;
            end else begin
               if (cpu_ce_q) begin
                  rem_d = rem_q - 1'b1;
                  if (rem_q == BURST_W'(1)) begin
                     state_d = S_IDLE;
                  end
               end
               cpu_ce_d = tick;
            end
         end
      endcase

      if (state_d == S_STEP) begin
         cpu_ce_d = 1'b1;
      end
      ce_count_d = ce_count_q + {15'd0, cpu_ce_d};
   end

   always_ff @(posedge clkin) begin
      if (reset) begin
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         db_q       <= 1'b0;
         db_cnt_q   <= '0;
         step_req_q <= 1'b0;
         state_q    <= S_IDLE;
         tick_cnt_q <= '0;
         rem_q      <= '0;
         cpu_ce_q   <= 1'b0;
         ce_count_q <= '0;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         db_q       <= db_d;
         db_cnt_q   <= db_cnt_d;
         step_req_q <= step_req_d;
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         rem_q      <= rem_d;
         cpu_ce_q   <= cpu_ce_d;
         ce_count_q <= ce_count_d;
      end
   end

   assign bus.cpu_ce   = cpu_ce_q;
   assign bus.mode     = state_q;
   assign bus.ce_count = ce_count_q;
endmodule

// File: tb/tb_cpu_clk_controller.sv
// Bench for cpu_clk_controller: cycle-level behavioural model plus directed scenarios
// with hand-computed pulse counts, spacings and ce_count values.
module tb_cpu_clk_controller;
   localparam int TP = 10;
   localparam int DB = 4;

   logic clkin = 1'b0;
   logic reset = 1'b1;
   always #5 clkin = ~clkin;

   cpu_clk_if #(.BURST_W(8)) bus ();

   cpu_clk_controller #(
      .IN_CLK_FRQ  (100),
      .RUN_FRQ     (10),
      .DEBOUNCE_CYC(DB),
      .BURST_W     (8)
   ) dut (
      .clkin(clkin),
      .reset(reset),
      .bus  (bus)
   );

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;
   int cyc = 0;
   int pulses = 0;
   int step_cycles = 0;
   int pq[$];

   // Model state: expected outputs for the current cycle plus button history.
   int m_mode = 0;
   bit m_ce = 1'b0;
   int m_cnt = 0;
   int m_rem = 0;
   int m_entry = 0;
   bit m_s1 = 1'b0, m_s2 = 1'b0, m_db = 1'b0, m_req = 1'b0;
   bit hist[DB];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clkin) begin
      int  n_mode, n_rem, n_entry;
      bit  n_ce, tick, all_diff, n_db;
      if (chk_en) begin
         check("mode", {30'd0, bus.mode}, m_mode);
         check("cpu_ce", {31'd0, bus.cpu_ce}, {31'd0, m_ce});
         check("ce_count", {16'd0, bus.ce_count}, m_cnt);
      end
      if (bus.cpu_ce === 1'b1) begin
         pulses++;
         pq.push_back(cyc);
      end
      if (bus.mode === 2'd2) step_cycles++;

      if (reset) begin
         m_mode = 0; m_ce = 0; m_cnt = 0; m_rem = 0;
         m_s1 = 0; m_s2 = 0; m_db = 0; m_req = 0;
         foreach (hist[i]) hist[i] = 1'b0;
      end else begin
         // debounced level flips once the last DB synchronized samples all disagree with it
         for (int i = DB - 1; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = m_s2;
         all_diff = 1'b1;
         foreach (hist[i]) all_diff &= (hist[i] != m_db);
         n_db = all_diff ? ~m_db : m_db;

         n_mode = m_mode; n_rem = m_rem; n_entry = m_entry; n_ce = 1'b0;
         tick = (m_mode == 1 || m_mode == 3) && (((cyc + 1 - m_entry) % TP) == 0);
         case (m_mode)
            0: if (!bus.cpu_halt) begin
                  if (bus.run_sw) begin
                     n_mode = 1; n_entry = cyc + 1;
                  end else if (m_req) begin
                     n_mode = 2;
                  end else if (bus.burst_go && bus.burst_len != 0) begin
                     n_mode = 3; n_rem = int'(bus.burst_len); n_entry = cyc + 1;
                  end
               end
            1: if (bus.cpu_halt || !bus.run_sw) n_mode = 0; else n_ce = tick;
            2: n_mode = 0;
            default: if (bus.cpu_halt) n_mode = 0;
               else begin
                  if (m_ce) begin
                     n_rem--;
                     if (n_rem == 0) n_mode = 0;
                  end
                  n_ce = tick;
               end
         endcase
         if (n_mode == 2) n_ce = 1'b1;

         m_cnt = (m_cnt + int'(n_ce)) % 65536;
         m_mode = n_mode; m_ce = n_ce; m_rem = n_rem; m_entry = n_entry;
         m_req = n_db & ~m_db;
         m_db = n_db;
         m_s2 = m_s1;
         m_s1 = bus.step_btn;
      end
      cyc++;
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clkin);
      #2;
   endtask

   task automatic clear_log();
      pulses = 0;
      step_cycles = 0;
      pq.delete();
   endtask

   task automatic check_spacing(input string name, input int base, input int first_off);
      if (pq.size() > 0) check({name, "_first"}, pq[0] - base, first_off);
      for (int i = 1; i < pq.size(); i++) check({name, "_gap"}, pq[i] - pq[i-1], TP);
   endtask

   initial begin
      int base;
      bus.run_sw = 0; bus.step_btn = 0; bus.burst_go = 0; bus.burst_len = '0; bus.cpu_halt = 0;

      // 1: reset then quiet
      wait_cyc(3);
      reset = 0;
      chk_en = 1'b1;
      clear_log();
      wait_cyc(50);
      check("t1_mode", {30'd0, bus.mode}, 0);
      check("t1_count", {16'd0, bus.ce_count}, 0);
      check("t1_pulses", pulses, 0);

      // 2: free-run for 55 cycles
      clear_log();
      base = cyc;
      bus.run_sw = 1;
      wait_cyc(55);
      bus.run_sw = 0;
      wait_cyc(20);
      check("t2_pulses", pulses, 5);
      check_spacing("t2", base, 11);
      check("t2_count", {16'd0, bus.ce_count}, 5);
      check("t2_mode", {30'd0, bus.mode}, 0);

      // 3: bouncing press gives one step; press during RUN gives none
      clear_log();
      bus.step_btn = 1; wait_cyc(1);
      bus.step_btn = 0; wait_cyc(1);
      bus.step_btn = 1; wait_cyc(20);
      bus.step_btn = 0; wait_cyc(12);
      check("t3_pulses", pulses, 1);
      check("t3_step_cycles", step_cycles, 1);
      check("t3_count", {16'd0, bus.ce_count}, 6);
      clear_log();
      bus.run_sw = 1; bus.step_btn = 1;
      wait_cyc(15);
      bus.run_sw = 0;
      wait_cyc(5);
      bus.step_btn = 0;
      wait_cyc(12);
      check("t3_run_step_cycles", step_cycles, 0);
      check("t3_run_pulses", pulses, 1);
      check("t3_run_count", {16'd0, bus.ce_count}, 7);

      // 4: burst of 3, a second burst_go mid-burst is ignored, then length 0
      clear_log();
      base = cyc;
      bus.burst_len = 8'd3; bus.burst_go = 1;
      wait_cyc(1);
      bus.burst_go = 0;
      wait_cyc(14);
      bus.burst_len = 8'd5; bus.burst_go = 1;
      wait_cyc(1);
      bus.burst_go = 0;
      wait_cyc(30);
      check("t4_pulses", pulses, 3);
      check_spacing("t4", base, 11);
      check("t4_count", {16'd0, bus.ce_count}, 10);
      check("t4_mode", {30'd0, bus.mode}, 0);
      clear_log();
      bus.burst_len = 8'd0; bus.burst_go = 1;
      wait_cyc(1);
      bus.burst_go = 0;
      wait_cyc(15);
      check("t4_zero_pulses", pulses, 0);
      check("t4_zero_count", {16'd0, bus.ce_count}, 10);

      // 5: burst of 5 aborted by cpu_halt after the 2nd pulse
      clear_log();
      bus.burst_len = 8'd5; bus.burst_go = 1;
      wait_cyc(1);
      bus.burst_go = 0;
      wait_cyc(22);
      bus.cpu_halt = 1;
      wait_cyc(2);
      bus.run_sw = 1; bus.step_btn = 1;
      wait_cyc(10);
      bus.step_btn = 0;
      wait_cyc(20);
      check("t5_pulses", pulses, 2);
      check("t5_count", {16'd0, bus.ce_count}, 12);
      check("t5_mode", {30'd0, bus.mode}, 0);
      bus.run_sw = 0; bus.cpu_halt = 0;
      wait_cyc(5);

      // 6: reset in the cycles around a burst tick, then count wrap
      clear_log();
      bus.burst_len = 8'd5; bus.burst_go = 1;
      wait_cyc(1);
      bus.burst_go = 0;
      wait_cyc(17);
      reset = 1;
      wait_cyc(2);
      reset = 0;
      wait_cyc(20);
      check("t6_pulses", pulses, 1);
      check("t6_count", {16'd0, bus.ce_count}, 0);
      check("t6_mode", {30'd0, bus.mode}, 0);

      clear_log();
      force dut.ce_count_q = 16'hFFFF;
      m_cnt = 16'hFFFF;
      #1;
      release dut.ce_count_q;
      wait_cyc(2);
      check("t6_preload", {16'd0, bus.ce_count}, 32'h0000FFFF);
      bus.step_btn = 1; wait_cyc(10);
      bus.step_btn = 0; wait_cyc(10);
      check("t6_wrap_pulses", pulses, 1);
      check("t6_wrap_count", {16'd0, bus.ce_count}, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/cpu_clk_controller.md
Name: cpu_clk_controller

Overview:
Sequences the 8-bit CPU's execution clock for bring-up and demo. It generates a one-cycle clock-enable pulse (cpu_ce) derived from the board clock, and supports four modes: free-run at a fixed rate, single-step from a debounced push-button, burst of N steps, and stop. It sits between the board clock/switches and the CPU core, and replaces direct use of a divided clock as the CPU clock.

Parameters:
IN_CLK_FRQ, 1000000, clkin frequency in Hz
RUN_FRQ, 10, cpu_ce pulse rate in RUN/BURST, Hz; TICK_PER = IN_CLK_FRQ / RUN_FRQ, must be >= 2
DEBOUNCE_CYC, 10000, consecutive stable clkin cycles required to accept a step_btn level change; >= 1
BURST_W, 8, width of burst_len

Ports:
clkin  in  1  system clock; all logic on its rising edge
reset  in  1  synchronous, active-high
run_sw  in  1  level, already synchronous; 1 = free-run request
step_btn  in  1  raw asynchronous push-button, active-high
burst_go  in  1  one-cycle pulse; start a burst
burst_len  in  BURST_W  step count, sampled on the accepted burst_go
cpu_halt  in  1  level from CPU, high after HLT executes
cpu_ce  out  1  one-cycle CPU clock-enable pulse
mode  out  2  current state: 0 IDLE, 1 RUN, 2 STEP, 3 BURST
ce_count  out  16  total cpu_ce pulses issued, wraps 0xFFFF -> 0

Behaviour:
- Reset, and any cycle with reset high, forces: mode=IDLE, cpu_ce=0, ce_count=0, tick counter=0, burst remaining=0. The debouncer is cleared to level 0 and its stability counter to 0. Reset overrides all other inputs.
- Tick counter: runs only in RUN/BURST and is cleared on entry to either. tick is asserted when counter == TICK_PER-1, then the counter wraps to 0. The first pulse therefore occurs TICK_PER cycles after entry, and subsequent pulses are spaced exactly TICK_PER cycles apart.
- cpu_ce: registered, high for exactly one clkin cycle per step; never high in IDLE. ce_count increments in the same cycle cpu_ce is high.
- step_btn path: 2-flop synchronizer, then debouncer. The debounced level changes only after the synchronized input has differed from it for DEBOUNCE_CYC consecutive cycles; any bounce restarts the count. A 0->1 transition of the debounced level produces a one-cycle step_req. A step_req arriving outside IDLE is discarded, not queued.
- IDLE transitions, with priority: (1) cpu_halt=1 -> stay IDLE, ignore all requests. (2) run_sw=1 -> RUN. (3) step_req -> STEP. (4) burst_go with burst_len != 0 -> BURST, remaining = burst_len. A burst_go with burst_len=0 is ignored.
- RUN: cpu_ce on each tick. cpu_halt=1 or run_sw=0 -> IDLE at the next edge. If the exit coincides with a tick, the exit wins and no pulse is issued.
- STEP: lasts exactly one cycle; cpu_ce=1 during it; then unconditionally -> IDLE. The pulse appears 1 cycle after step_req.
- BURST: on each tick, cpu_ce=1 and remaining decrements. When the pulse is issued with remaining==1, the state goes -> IDLE. cpu_halt=1 aborts -> IDLE immediately (a coincident tick is suppressed). run_sw, step_req and burst_go are ignored during BURST. Exactly burst_len pulses are issued unless aborted.
- mode reflects the registered state, so it changes the cycle after the transitioning edge.

Test Plan (IN_CLK_FRQ=100, RUN_FRQ=10 -> TICK_PER=10, DEBOUNCE_CYC=4, BURST_W=8):
1. Reset held 3 cycles, then released with all inputs 0 -> mode=0, cpu_ce=0, ce_count=0 for 50 cycles.
2. Raise run_sw for 55 cycles, then drop it -> cpu_ce pulses at cycles 10, 20, 30, 40, 50 after entering RUN, 5 pulses, ce_count=5, mode returns to 0, no further pulses.
3. step_btn bounces 1,0,1 at 1-cycle intervals, then holds 1 for 20 cycles -> exactly one cpu_ce pulse, and mode passes through 2 for exactly one cycle. A second press while run_sw=1 yields no STEP.
4. burst_go with burst_len=3 -> exactly 3 pulses, 10 cycles apart, then mode=0 and ce_count=+3. burst_go with burst_len=0 -> no change. burst_go during BURST -> ignored.
5. burst_len=5 with cpu_halt raised after the 2nd pulse -> mode=0, only 2 pulses. While cpu_halt=1, run_sw=1 and step presses produce no cpu_ce.
6. Reset asserted mid-BURST, 1 cycle before a tick -> no pulse, everything cleared. Separately, preload ce_count to 0xFFFF via 65535 pulses (or force), then issue one step -> ce_count=0.
